// File: rtl/sa_main.sv
// Switch allocator: one round-robin arbiter per router output port, with packet-level locking
// so that a multi-flit packet holds its output until the tail flit is granted.
module sa_main #(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_from_P0,
    input  logic [N-1:0]   req_from_P1,
    input  logic [N-1:0]   req_from_P2,
    input  logic [N-1:0]   req_from_P3,
    input  logic [N-1:0]   req_from_P4,
    input  logic           tail_from_P0,
    input  logic           tail_from_P1,
    input  logic           tail_from_P2,
    input  logic           tail_from_P3,
    input  logic           tail_from_P4,
    input  logic [N-1:0]   credit_avail,
    output logic [N-1:0]   sel_for_OP0,
    output logic [N-1:0]   sel_for_OP1,
    output logic [N-1:0]   sel_for_OP2,
    output logic [N-1:0]   sel_for_OP3,
    output logic [N-1:0]   sel_for_OP4,
    output logic [N-1:0]   grant_to_P,
    output logic [3*N-1:0] dbg_ptr,
    output logic [N-1:0]   dbg_lock_vld,
    output logic [3*N-1:0] dbg_lock_idx
);

    // Handshake: req_from_Pi[j] is the valid of input i towards output j; sel_for_OPj[i] is
    // the matching ready. A flit moves in exactly the cycle where both are high; there is no
    // holding register, so a request that is not selected must simply be presented again.

    logic [N-1:0] req_raw  [N];
    logic [N-1:0] req_eff  [N];
    logic [N-1:0] cand     [N];
    logic [N-1:0] tail;

    logic [2:0]   ptr_q      [N];
    logic [2:0]   ptr_d      [N];
    logic [N-1:0] lock_vld_q;
    logic [N-1:0] lock_vld_d;
    logic [2:0]   lock_idx_q [N];
    logic [2:0]   lock_idx_d [N];

    logic [N-1:0] sel      [N];
    logic [N-1:0] win_vld;
    logic [2:0]   win_idx  [N];

    assign req_raw[0] = req_from_P0;
    assign req_raw[1] = req_from_P1;
    assign req_raw[2] = req_from_P2;
    assign req_raw[3] = req_from_P3;
    assign req_raw[4] = req_from_P4;
    assign tail       = {tail_from_P4, tail_from_P3, tail_from_P2, tail_from_P1, tail_from_P0};

    // A multi-hot request is reduced to its lowest set bit, then transposed per output.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_eff[i] = req_raw[i] & (~req_raw[i] + 1'b1);
        end
        for (int j = 0; j < N; j++) begin
            cand[j] = '0;
            for (int i = 0; i < N; i++) begin
                cand[j][i] = req_eff[i][j];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld_q <= '0;
            for (int j = 0; j < N; j++) begin
                ptr_q[j]      <= 3'd0;
                lock_idx_q[j] <= 3'd0;
            end
        end else begin
            lock_vld_q <= lock_vld_d;
            for (int j = 0; j < N; j++) begin
                ptr_q[j]      <= ptr_d[j];
                lock_idx_q[j] <= lock_idx_d[j];
            end
        end
    end

    // Output logic: the grant decision is purely combinational from the current requests.
    always_comb begin
        win_vld = '0;
        for (int j = 0; j < N; j++) begin
            sel[j]     = '0;
            win_idx[j] = 3'd0;
            if (!rst && credit_avail[j]) begin
                if (lock_vld_q[j]) begin
                    if (cand[j][lock_idx_q[j]]) begin
                        win_vld[j] = 1'b1;
                        win_idx[j] = lock_idx_q[j];
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (!win_vld[j] && cand[j][(int'(ptr_q[j]) + k) % N]) begin
                            win_vld[j] = 1'b1;
                            win_idx[j] = 3'((int'(ptr_q[j]) + k) % N);
                        end
                    end
                end
            end
            if (win_vld[j]) begin
                sel[j] = N'(1) << win_idx[j];
            end
        end
    end

    // Next-state logic: the pointer only moves past a packet once its tail is granted.
    always_comb begin
        lock_vld_d = lock_vld_q;
        for (int j = 0; j < N; j++) begin
            ptr_d[j]      = ptr_q[j];
            lock_idx_d[j] = lock_idx_q[j];
            if (win_vld[j]) begin
                if (tail[win_idx[j]]) begin
                    lock_vld_d[j] = 1'b0;
                    ptr_d[j]      = (win_idx[j] == 3'(N - 1)) ? 3'd0 : win_idx[j] + 3'd1;
                end else begin
                    lock_vld_d[j] = 1'b1;
                    lock_idx_d[j] = win_idx[j];
                end
            end
        end
    end

    always_comb begin
        grant_to_P = '0;
        for (int j = 0; j < N; j++) begin
            grant_to_P = grant_to_P | sel[j];
        end
    end

    assign sel_for_OP0  = sel[0];
    assign sel_for_OP1  = sel[1];
    assign sel_for_OP2  = sel[2];
    assign sel_for_OP3  = sel[3];
    assign sel_for_OP4  = sel[4];
    assign dbg_lock_vld = lock_vld_q;

    for (genvar g = 0; g < N; g++) begin : g_dbg
        assign dbg_ptr[3*g +: 3]      = ptr_q[g];
        assign dbg_lock_idx[3*g +: 3] = lock_idx_q[g];
    end

endmodule

// File: tb/tb_sa_main.sv
// Bench for sa_main: a per-cycle reference model of the allocator plus directed scenarios
// with hand-computed selections.
module tb_sa_main;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req [N];
    logic [N-1:0]   tail;
    logic [N-1:0]   credit;
    logic [N-1:0]   dut_sel [N];
    logic [N-1:0]   grant;
    logic [3*N-1:0] dbg_ptr;
    logic [N-1:0]   dbg_lock_vld;
    logic [3*N-1:0] dbg_lock_idx;

    int errors = 0;
    int checks = 0;

    // Reference state: round-robin pointer and packet lock per output.
    int m_ptr [N];
    int m_lv  [N];
    int m_li  [N];

    // Clock / reset
    always #5 clk = ~clk;

    sa_main #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_from_P0  (req[0]),
        .req_from_P1  (req[1]),
        .req_from_P2  (req[2]),
        .req_from_P3  (req[3]),
        .req_from_P4  (req[4]),
        .tail_from_P0 (tail[0]),
        .tail_from_P1 (tail[1]),
        .tail_from_P2 (tail[2]),
        .tail_from_P3 (tail[3]),
        .tail_from_P4 (tail[4]),
        .credit_avail (credit),
        .sel_for_OP0  (dut_sel[0]),
        .sel_for_OP1  (dut_sel[1]),
        .sel_for_OP2  (dut_sel[2]),
        .sel_for_OP3  (dut_sel[3]),
        .sel_for_OP4  (dut_sel[4]),
        .grant_to_P   (grant),
        .dbg_ptr      (dbg_ptr),
        .dbg_lock_vld (dbg_lock_vld),
        .dbg_lock_idx (dbg_lock_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Destination port of a request: its lowest set bit, or -1 for no request.
    function automatic int dest(input logic [N-1:0] r);
        for (int b = 0; b < N; b++) begin
            if (r[b]) return b;
        end
        return -1;
    endfunction

    // Scoreboard: predict every output from the rules, compare, then advance the model.
    always @(negedge clk) begin
        int w [N];
        int cand_i;
        logic [N-1:0] es;
        logic [N-1:0] eg;
        eg = '0;
        for (int j = 0; j < N; j++) begin
            w[j] = -1;
            if (rst !== 1'b1 && credit[j]) begin
                if (m_lv[j] != 0) begin
                    if (dest(req[m_li[j]]) == j) w[j] = m_li[j];
                end else begin
                    for (int k = 0; k < N; k++) begin
                        cand_i = (m_ptr[j] + k) % N;
                        if (w[j] < 0 && dest(req[cand_i]) == j) w[j] = cand_i;
                    end
                end
            end
            es = '0;
            if (w[j] >= 0) begin
                es[w[j]] = 1'b1;
                eg[w[j]] = 1'b1;
            end
            check($sformatf("model sel_for_OP%0d", j), 32'(dut_sel[j]), 32'(es));
            check($sformatf("model ptr_%0d", j), 32'(dbg_ptr[3*j +: 3]), 32'(m_ptr[j]));
            check($sformatf("model lock_vld_%0d", j), 32'(dbg_lock_vld[j]), 32'(m_lv[j]));
            if (m_lv[j] != 0)
                check($sformatf("model lock_idx_%0d", j), 32'(dbg_lock_idx[3*j +: 3]), 32'(m_li[j]));
        end
        check("model grant_to_P", 32'(grant), 32'(eg));
        for (int j = 0; j < N; j++) begin
            if (rst === 1'b1) begin
                m_ptr[j] = 0;
                m_lv[j]  = 0;
            end else if (w[j] >= 0) begin
                if (tail[w[j]]) begin
                    m_lv[j]  = 0;
                    m_ptr[j] = (w[j] + 1) % N;
                end else begin
                    m_lv[j] = 1;
                    m_li[j] = w[j];
                end
            end
        end
    end

    // Driver tasks
    task automatic idle();
        for (int i = 0; i < N; i++) req[i] = '0;
        tail   = '0;
        credit = '1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int j = 0; j < N; j++) begin
            m_ptr[j] = 0;
            m_lv[j]  = 0;
            m_li[j]  = 0;
        end
        rst = 1'b1;
        idle();
        req[1] = 5'b00100;
        adv();
        smp();
        check("reset sel_for_OP2", 32'(dut_sel[2]), 32'h0);
        check("reset grant", 32'(grant), 32'h0);
        adv();
        // Simultaneous single-flit requests rotate around OP2.
        rst = 1'b0;
        req[1] = 5'b00100; req[3] = 5'b00100; req[4] = 5'b00100;
        tail = 5'b11111;
        smp(); check("rr c1 sel_for_OP2", 32'(dut_sel[2]), 32'b00010);
        adv(); smp(); check("rr c2 sel_for_OP2", 32'(dut_sel[2]), 32'b01000);
        adv(); smp(); check("rr c3 sel_for_OP2", 32'(dut_sel[2]), 32'b10000);
        adv(); idle(); smp();
        check("rr ptr_2 end", 32'(dbg_ptr[6 +: 3]), 32'd0);
        // Three-flit packet from P0 locks OP1 against P2.
        adv(); req[0] = 5'b00010; req[2] = 5'b00010; tail[2] = 1'b1;
        smp(); check("lock f1 sel_for_OP1", 32'(dut_sel[1]), 32'b00001);
        check("lock f1 grant P2", 32'(grant[2]), 32'd0);
        adv(); smp(); check("lock f2 sel_for_OP1", 32'(dut_sel[1]), 32'b00001);
        check("lock f2 grant P2", 32'(grant[2]), 32'd0);
        adv(); tail[0] = 1'b1;
        smp(); check("lock f3 sel_for_OP1", 32'(dut_sel[1]), 32'b00001);
        check("lock f3 grant P2", 32'(grant[2]), 32'd0);
        adv(); req[0] = '0;
        smp(); check("lock after sel_for_OP1", 32'(dut_sel[1]), 32'b00100);
        // Credit stall while P3 holds OP4.
        adv(); idle(); req[3] = 5'b10000;
        smp(); check("stall f1 sel_for_OP4", 32'(dut_sel[4]), 32'b01000);
        adv(); credit[4] = 1'b0; req[1] = 5'b10000; tail[1] = 1'b1;
        smp(); check("stall c1 sel_for_OP4", 32'(dut_sel[4]), 32'b00000);
        check("stall c1 grant P3", 32'(grant[3]), 32'd0);
        check("stall c1 lock_vld_4", 32'(dbg_lock_vld[4]), 32'd1);
        adv(); smp(); check("stall c2 sel_for_OP4", 32'(dut_sel[4]), 32'b00000);
        check("stall c2 grant P3", 32'(grant[3]), 32'd0);
        adv(); credit[4] = 1'b1;
        smp(); check("stall resume sel_for_OP4", 32'(dut_sel[4]), 32'b01000);
        adv(); tail[3] = 1'b1;
        smp(); check("stall tail sel_for_OP4", 32'(dut_sel[4]), 32'b01000);
        adv(); req[3] = '0;
        smp(); check("stall next sel_for_OP4", 32'(dut_sel[4]), 32'b00010);
        // Parallel permutation with no conflicts.
        adv(); idle(); tail = 5'b11111;
        req[0] = 5'b00010; req[1] = 5'b00100; req[2] = 5'b01000;
        req[3] = 5'b10000; req[4] = 5'b00001;
        smp(); check("perm grant", 32'(grant), 32'b11111);
        check("perm sel_for_OP0", 32'(dut_sel[0]), 32'b10000);
        check("perm sel_for_OP3", 32'(dut_sel[3]), 32'b00100);
        // Reset in the middle of a locked P2->OP0 packet.
        adv(); idle(); req[2] = 5'b00001;
        smp(); check("rstmid f1 sel_for_OP0", 32'(dut_sel[0]), 32'b00100);
        adv(); rst = 1'b1; req[1] = 5'b00001; tail[1] = 1'b1;
        smp(); check("rstmid rst sel_for_OP0", 32'(dut_sel[0]), 32'b00000);
        check("rstmid rst grant", 32'(grant), 32'h0);
        adv(); rst = 1'b0;
        smp(); check("rstmid after sel_for_OP0", 32'(dut_sel[0]), 32'b00010);
        check("rstmid after grant", 32'(grant), 32'b00010);
        // Multi-hot request honours only the lowest bit.
        adv(); idle(); req[1] = 5'b10100; tail[1] = 1'b1;
        smp(); check("multihot sel_for_OP2", 32'(dut_sel[2]), 32'b00010);
        check("multihot sel_for_OP4 P1", 32'(dut_sel[4][1]), 32'd0);
        check("multihot grant", 32'(grant), 32'b00010);
        adv(); idle();
        smp();
        adv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sa_main.md
SA_MAIN -- requirements
Module: sa_main

Interface
REQ-001 SHALL use parameter N, default 5 (from params.vh): the number of router ports, which is also the number of crossbar inputs and outputs.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports req_from_P0..P4, input, N bits each: the requested output port of each input port's local-arbitration winner, one-hot, with all-zero meaning no request.
REQ-005 SHALL have ports tail_from_P0..P4, input, 1 bit each: the requesting flit of that input is a tail flit (single-flit packets assert tail).
REQ-006 SHALL have port credit_avail, input, N bits: bit j high means output port j has at least one downstream credit.
REQ-007 SHALL have ports sel_for_OP0..OP4, output, N bits each: the one-hot input selected for each output port, driven straight into the crossbar select inputs.
REQ-008 SHALL have port grant_to_P, output, N bits: bit i high means input i won an output this cycle.

Function
REQ-009 SHALL contain one round-robin arbiter per output port j, with a priority pointer ptr_j (3 bits, range 0..4) and a lock state lock_vld_j / lock_idx_j.
REQ-010 SHALL make output j's candidate set the inputs i with req_from_Pi[j]=1, evaluated combinationally in the same cycle (zero-cycle grant latency).
REQ-011 SHALL honour only the lowest set bit of a multi-hot req_from_Pi; a multi-hot request is a protocol violation but must still be handled deterministically.
REQ-012 SHALL drive sel_for_OPj = 0 when credit_avail[j]=0, whatever the requests.
REQ-013 SHALL, when unlocked, select the first requesting input found by searching from ptr_j upward with wrap-around, in the order ptr_j, ptr_j+1, ..., 4, 0, ..., ptr_j-1.
REQ-014 SHALL, when locked, consider only input lock_idx_j: sel_for_OPj = one-hot(lock_idx_j) if that input requests j and has credit, otherwise 0; no other input may be granted j while locked.
REQ-015 SHALL keep every sel_for_OPj one-hot or zero at all times.
REQ-016 SHALL set grant_to_P[i] = OR over j of sel_for_OPj[i]; at most one bit per input can be high because requests are one-hot.
REQ-017 SHALL, on a granted non-tail flit from input i at output j, set lock_vld_j=1 and lock_idx_j=i at the next edge.
REQ-018 SHALL, on a granted tail flit at output j, clear lock_vld_j and set ptr_j=(i+1) mod 5 at the next edge.
REQ-019 SHALL leave ptr_j unchanged on non-tail grants (packet-level fairness) and in cycles with no grant.
REQ-020 SHALL update all five arbiters independently, with simultaneous locks and releases on different outputs allowed in the same cycle.
REQ-021 SHALL handle a same-cycle tail grant and new request to the same output as follows: the released lock takes effect only from the next cycle, so the new packet competes in the following cycle.

Reset
REQ-022 SHALL, while rst=1, force all sel_for_OPj=0 and grant_to_P=0.
REQ-023 SHALL, on a reset edge, set ptr_j=0 and lock_vld_j=0 for all j; lock_idx_j is don't-care.
REQ-024 SHALL let an assertion of rst mid-packet abandon the lock; after rst falls, arbitration restarts from ptr=0 with P0 at highest priority.
REQ-025 SHALL make the first cycle with rst=0 evaluate requests normally.

Verification
REQ-026 SHALL cover simultaneous requests: after reset, P1, P3 and P4 all request OP2 with tail=1 and credit_avail=5'b11111 for 3 cycles -> sel_for_OP2 = 00010, 01000, 10000 on successive cycles, and ptr_2 ends at 0.
REQ-027 SHALL cover packet locking: P0 sends a 3-flit packet to OP1 (tail only on flit 3) while P2 continuously requests OP1 -> sel_for_OP1 = 00001 for 3 cycles, then 00100; grant_to_P[2]=0 throughout the P0 packet.
REQ-028 SHALL cover credit stall: P3 is locked on OP4 and credit_avail[4] drops for 2 cycles -> sel_for_OP4=0 and grant_to_P[3]=0 for those 2 cycles, the lock is held, and P3 resumes with no other input interleaving.
REQ-029 SHALL cover the parallel no-conflict case: P0->OP1, P1->OP2, P2->OP3, P3->OP4 and P4->OP0 in the same cycle -> all five grants are high and grant_to_P=5'b11111.
REQ-030 SHALL cover reset mid-packet: rst is asserted for 1 cycle during a locked P2->OP0 packet, then P1 and P2 request OP0 -> sel_for_OP0=00000 during rst, then 00010 (P1 wins because ptr=0).
REQ-031 SHALL cover multi-hot requests: req_from_P1=5'b10100 -> only sel_for_OP2 can select P1, and sel_for_OP4[1] stays 0.
